// File: rtl/cs0_mem_pkg.sv
// Shared types and constants for the CS0 memory bridge.
package cs0_mem_pkg;

  typedef enum logic [2:0] {IDLE, WAIT, REQ, BUSY, DONE} state_t;

  localparam logic        MEM_SEL_ROM  = 1'b0;
  localparam logic        MEM_SEL_SRAM = 1'b1;
  localparam logic [15:0] DO_IDLE      = 16'hFFFF;

  // The counter is loaded on the start tick, so a wait of N ticks loads N-1.
  // A wait of 0 still spends one tick in WAIT.
  function automatic logic [3:0] wait_load(input logic [3:0] n);
    return (n == 4'd0) ? 4'd0 : n - 4'd1;
  endfunction

endpackage

// File: rtl/cs0_wait_cnt.sv
// 4-bit loadable down-counter with clock enable and zero flag; saturates at 0.
module cs0_wait_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] cnt;

  // Load wins over decrement; never wraps below zero.
  always_ff @(posedge clk) begin
    if (rst)                     cnt <= 4'd0;
    else if (load)               cnt <= load_val;
    else if (ce && cnt != 4'd0)  cnt <= cnt - 4'd1;
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/cs0_mem_bridge.sv
// cs0_mem_bridge: turns each SH-2 CS0 ROM / backup-SRAM bus cycle into one
// request/ready transaction on the external memory port, holding WTIN_N low
// until the data is ready and for at least ROM_WAIT / SRAM_WAIT CE_R ticks.
// Optional macro CS0_MEM_TIMEOUT_EN: a BUSY timeout of TIMEOUT CE_R ticks
// forces completion (reads return 16'hFFFF).
module cs0_mem_bridge
  import cs0_mem_pkg::*;
#(
  parameter int ROM_WAIT  = 2,
  parameter int SRAM_WAIT = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_R,
  input  logic [18:0] A,
  input  logic [15:0] DI,
  output logic [15:0] DO,
  input  logic        ROMCE_N,
  input  logic        SRAMCE_N,
  input  logic        MOE_N,
  input  logic        MWR_N,
  output logic        WTIN_N,
  output logic [18:0] MEM_ADDR,
  output logic        MEM_SEL,
  output logic        MEM_RD,
  output logic        MEM_WR,
  output logic [7:0]  MEM_DIN,
  input  logic [15:0] MEM_DOUT,
  input  logic        MEM_RDY
);

  localparam logic [3:0] ROM_LD  = wait_load(4'(ROM_WAIT));
  localparam logic [3:0] SRAM_LD = wait_load(4'(SRAM_WAIT));
  localparam logic [7:0] TMO     = 8'(TIMEOUT);

  state_t state, state_nxt;
  logic   sel, strb, active, start;
  logic   rd;
  logic   wait_zero;
  logic   req_fire, rsp_take, tmo_hit, tmo_reach;
  logic   unused_di;

  assign unused_di = ^DI[15:8];

  assign sel    = ~ROMCE_N | ~SRAMCE_N;
  assign strb   = ~MOE_N | ~MWR_N;
  assign active = sel & strb;
  assign start  = active & (state == IDLE);

  // No register in the path: the bus controller sees the wait on the first strobe cycle.
  assign WTIN_N = ~(active & (start | (state inside {WAIT, REQ, BUSY})));

  cs0_wait_cnt u_wait (
    .clk      (CLK),
    .rst      (RST),
    .ce       (CE_R && state == WAIT),
    .load     (CE_R && start),
    .load_val (~SRAMCE_N ? SRAM_LD : ROM_LD),
    .zero     (wait_zero)
  );

`ifdef CS0_MEM_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  // Counts CE_R ticks spent in BUSY; cleared whenever BUSY is left.
  always_ff @(posedge CLK) begin
    if (RST || state != BUSY) tmo_cnt <= 8'd0;
    else if (CE_R)            tmo_cnt <= tmo_cnt + 8'd1;
  end

  assign tmo_reach = CE_R && ((tmo_cnt + 8'd1) == TMO);
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO;
  assign tmo_reach  = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state. REQ and BUSY react on any CLK: the request is a one-CLK
  // pulse and MEM_RDY is a one-CLK completion that must not be missed.
  always_comb begin
    state_nxt = state;
    req_fire  = 1'b0;
    rsp_take  = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: if (CE_R && start) state_nxt = WAIT;
      WAIT: if (CE_R) begin
        if (!active)        state_nxt = IDLE;
        else if (wait_zero) state_nxt = REQ;
      end
      REQ: begin
        if (!active) state_nxt = IDLE;
        else if (rd || MEM_SEL == MEM_SEL_SRAM) begin
          req_fire  = 1'b1;
          state_nxt = BUSY;
        end else state_nxt = DONE;   // ROM write: nothing to do
      end
      BUSY: begin
        if (MEM_RDY) begin
          rsp_take  = 1'b1;
          state_nxt = active ? DONE : IDLE;
        end else if (tmo_reach) begin
          tmo_hit   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    if (CE_R && !active) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, request pulses and read data capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      DO       <= DO_IDLE;
      MEM_RD   <= 1'b0;
      MEM_WR   <= 1'b0;
      MEM_ADDR <= 19'd0;
      MEM_SEL  <= MEM_SEL_ROM;
      MEM_DIN  <= 8'd0;
      rd       <= 1'b0;
    end else begin
      MEM_RD <= req_fire & rd;
      MEM_WR <= req_fire & ~rd;
      if (CE_R && start) begin
        MEM_ADDR <= A;
        MEM_SEL  <= ~SRAMCE_N ? MEM_SEL_SRAM : MEM_SEL_ROM;
        MEM_DIN  <= DI[7:0];
        rd       <= ~MOE_N;
      end
      if (rsp_take && rd)     DO <= MEM_DOUT;
      else if (tmo_hit && rd) DO <= DO_IDLE;
    end
  end

endmodule

// File: doc/cs0_mem_bridge.md
Name: cs0_mem_bridge

Overview:
- Sits directly downstream of the system bus controller. It consumes that controller's decoded CS0 strobes: ROMCE_N, SRAMCE_N, MOE_N and MWR_N.
- Converts each SH-2 CS0 ROM or backup-SRAM bus cycle into a single request/ready transaction on the external memory port (BIOS ROM and backup RAM are held in SDRAM/BRAM).
- Drives WTIN_N back to the bus controller, stretching the SH-2 cycle until the data is ready.
- Enforces a programmable minimum wait per region.

Parameters:
- ROM_WAIT, 2, minimum CE_R ticks WTIN_N is held low for a ROM cycle (0-15).
- SRAM_WAIT, 4, minimum CE_R ticks WTIN_N is held low for a backup-SRAM cycle (0-15).
- TIMEOUT, 255, CE_R ticks without MEM_RDY before a forced completion (only with the optional feature).

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- CE_R  in  1  rising-phase clock enable; all state advances only when CE_R=1
- A  in  19  bus address A[19:1]
- DI  in  16  write data from the SH-2 bus
- DO  out  16  read data to the SH-2 bus
- ROMCE_N  in  1  ROM select, active-low
- SRAMCE_N  in  1  backup-SRAM select, active-low
- MOE_N  in  1  read strobe, active-low
- MWR_N  in  1  write strobe, active-low
- WTIN_N  out  1  wait request to the bus controller, active-low
- MEM_ADDR  out  19  latched word address
- MEM_SEL  out  1  0=ROM, 1=SRAM
- MEM_RD  out  1  read request, one CLK-cycle pulse
- MEM_WR  out  1  write request, one CLK-cycle pulse
- MEM_DIN  out  8  SRAM write byte (DI[7:0], odd lane)
- MEM_DOUT  in  16  read data
- MEM_RDY  in  1  single-cycle completion pulse; sampled on any CLK edge, not only CE_R

Behaviour:
- Reset (RST=1 at a CLK edge) applies regardless of CE_R:
  - State=IDLE; wait counter cleared.
  - DO=16'hFFFF, MEM_RD=0, MEM_WR=0, MEM_ADDR=0, MEM_SEL=0, MEM_DIN=0.
  - WTIN_N=1.
- Definitions:
  - sel = ~ROMCE_N | ~SRAMCE_N.
  - strb = ~MOE_N | ~MWR_N.
  - start = sel & strb & state==IDLE.
- WTIN_N is combinational: WTIN_N = ~(sel & strb & (start | state in {WAIT, REQ, BUSY})). It goes low in the same cycle the strobe is first seen, with no bubble.
- States:
  - IDLE, on start at a CE_R tick:
    - Latch MEM_ADDR=A, MEM_SEL=~SRAMCE_N (SRAM wins if both selects are low), MEM_DIN=DI[7:0], and the direction (rd=~MOE_N).
    - Load the wait counter with ROM_WAIT or SRAM_WAIT.
    - Go to WAIT.
  - WAIT: decrement the counter each CE_R tick; at 0 go to REQ.
  - REQ:
    - Read: pulse MEM_RD for one CLK, then go to BUSY.
    - Write to SRAM: pulse MEM_WR for one CLK, then go to BUSY.
    - Write to ROM: no request, go straight to DONE.
  - BUSY: on MEM_RDY (any CLK), for reads latch DO=MEM_DOUT, then go to DONE.
  - DONE: WTIN_N=1. Return to IDLE at the first CE_R tick with strb=0 or sel=0.
- A strobe dropped early (bus abort) in WAIT or REQ returns to IDLE with no memory request.
- A strobe dropped early in BUSY stays in BUSY until MEM_RDY arrives; the memory transaction always completes. The block then goes to IDLE directly.
- A new start is never accepted outside IDLE.
- MEM_RDY outside BUSY is ignored.
- Back-to-back cycles: the minimum IDLE gap is one CE_R tick.
- The wait counter is 4 bits and never underflows; a WAIT value of 0 goes from WAIT to REQ on the next tick.

Optional Feature:
- Macro: CS0_MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit counter counts CE_R ticks while in BUSY.
  - When the count reaches TIMEOUT with no MEM_RDY, reads load DO=16'hFFFF and the state goes to DONE.
  - A late MEM_RDY is ignored.
- Undefined: BUSY waits indefinitely for MEM_RDY; the counter logic is absent.

Decomposition:
- Package cs0_mem_pkg holds:
  - the state enum (IDLE, WAIT, REQ, BUSY, DONE);
  - MEM_SEL_ROM/MEM_SEL_SRAM constants;
  - the DO idle value 16'hFFFF.
- Optional sub-module cs0_wait_cnt: a 4-bit loadable down-counter with CE and zero flag.

Test Plan:
- ROM read, A=19'h00010, MEM_DOUT=16'h1234, MEM_RDY 3 CLK after MEM_RD:
  - WTIN_N low the same cycle the strobe appears.
  - Exactly one MEM_RD pulse, issued after 2 CE_R ticks, with MEM_SEL=0.
  - DO=16'h1234 and WTIN_N=1 the cycle after MEM_RDY.
- SRAM write, DI=16'h00A5:
  - One MEM_WR pulse with MEM_SEL=1 and MEM_DIN=8'hA5, after 4 CE_R ticks.
  - WTIN_N released after MEM_RDY.
- ROM write: no MEM_RD/MEM_WR pulse; WTIN_N low for exactly 2 CE_R ticks.
- Strobe dropped during WAIT: no memory request, back in IDLE, WTIN_N=1. Strobe dropped in BUSY: the block holds until MEM_RDY, then returns to IDLE.
- RST=1 asserted in BUSY:
  - The next cycle shows WTIN_N=1, MEM_RD=0, MEM_WR=0, DO=16'hFFFF.
  - A subsequent MEM_RDY is ignored.
- With CS0_MEM_TIMEOUT_EN defined, never assert MEM_RDY: after 255 CE_R ticks in BUSY, DO=16'hFFFF and WTIN_N=1. Without the macro, WTIN_N stays low.
